ternary_fetch_unit: RTL and testbench
=====================================

# ternary_fetch_unit

Instruction fetch sequencer for the ternary core. Reads the current address from the program counter, issues a single-outstanding read to instruction memory, and hands the returned word to the decoder over a valid/ready handshake. It also drives the program counter's update port with a ternary +1 step. Trit-encoding faults in returned words raise a sticky error.

## Interface
Parameters (from `parameters.vh`):
- WORD_SIZE, 9, instruction/data width in trits; buses are 2*WORD_SIZE bits, 2 bits per trit.
- MEM_ADDR_SIZE, 6, address width in trits; buses are 2*MEM_ADDR_SIZE bits.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  core permits new fetches.
- flush  in  1  discard buffered or in-flight instruction (branch/reset of flow).
- pc  in  2*MEM_ADDR_SIZE  current program counter value.
- pc_update  out  1  one-cycle pulse to the program counter's update enable.
- pc_step  out  2*WORD_SIZE  constant ternary +1: least significant trit = one-trit macro, all others = zero-trit macro.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  2*MEM_ADDR_SIZE  read address, stable while mem_req=1.
- mem_ready  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  2*WORD_SIZE  returned instruction word.
- instr_valid  out  1  instr/instr_addr hold a deliverable instruction.
- instr_ready  in  1  decoder accepts instruction.
- instr  out  2*WORD_SIZE  fetched instruction.
- instr_addr  out  2*MEM_ADDR_SIZE  address instr was fetched from.
- fetch_error  out  1  sticky: an invalid trit code was returned.

## Operation
- Zero word = every trit the zero-trit macro. Invalid trit = 2'b11 (unassigned code).
- All outputs registered except pc_step (constant).
- States: IDLE, REQ, HOLD, ERROR.
- IDLE: mem_req=0. If fetch_enable=1 and flush=0: mem_addr<=pc, -> REQ.
- REQ: mem_req=1, mem_addr held. Request is never withdrawn before mem_ready.
  - flush=1 without mem_ready: set internal drop flag, stay in REQ.
  - mem_ready=1, drop flag set (or flush=1 same cycle): discard data, clear flag, no pc_update, -> IDLE.
  - mem_ready=1, any trit of mem_rdata invalid: fetch_error<=1, no pc_update, -> ERROR.
  - mem_ready=1, data valid: instr<=mem_rdata, instr_addr<=mem_addr, instr_valid<=1, pc_update<=1 for exactly one cycle, -> HOLD.
- HOLD: instr_valid=1, instr/instr_addr stable.
  - flush=1: instr_valid<=0, -> IDLE; flush beats a simultaneous instr_ready (no transfer counted).
  - instr_ready=1: instr_valid<=0, -> IDLE.
- ERROR: mem_req=0, instr_valid=0, fetch_error=1. flush=1 clears fetch_error, -> IDLE. Only flush or reset exits.
- fetch_enable deasserting only prevents leaving IDLE; it never aborts REQ or HOLD.
- reset_n low at any time (mid-request included): immediately state=IDLE, mem_req=0, mem_addr=zero word, instr=zero word, instr_addr=zero word, instr_valid=0, pc_update=0, fetch_error=0, drop flag=0.

## Timing
- IDLE->REQ: mem_req rises on the edge after fetch_enable is sampled high.
- Memory response: mem_ready sampled at posedge; instr_valid and pc_update rise on that same edge.
- pc_update is high for the first HOLD cycle only; the program counter registers pc+1 at the end of that cycle.
- Handshake completes on the posedge where instr_valid=1 and instr_ready=1.
- The mandatory IDLE cycle after HOLD guarantees pc already reflects the update before the next address is sampled.
- Minimum fetch period with zero-wait memory (mem_ready in first REQ cycle) and instr_ready held high: 3 cycles (IDLE, REQ, HOLD).
- One outstanding request maximum; no pipelining.

## Test plan
- Reset with reset_n=0 mid-REQ (mem_req=1) -> mem_req, instr_valid, pc_update, and fetch_error drop asynchronously to 0; mem_addr=zero word.
- pc=address 5, fetch_enable=1, mem_ready after 2 wait cycles, instr_ready=1 -> mem_addr=5; instr=mem_rdata; instr_addr=5; single pc_update pulse; next request uses address 6.
- instr_ready held 0 for 4 cycles in HOLD -> instr/instr_valid stable for all 4 cycles; no second mem_req; pc_update pulses once only.
- flush during REQ before mem_ready -> mem_req stays high until mem_ready; data discarded; no instr_valid; no pc_update; returns to IDLE.
- flush and instr_ready both high in HOLD -> instr_valid falls; transfer not counted; next fetch from current pc.
- mem_rdata with one trit = 2'b11 -> fetch_error=1, no instr_valid, no pc_update, no further mem_req until flush; flush clears error and fetching resumes.

Source files
------------

// File: rtl/ternary_fetch_unit.sv
// ternary_fetch_unit
// Instruction fetch sequencer for the ternary core. It samples the program
// counter, issues one read at a time to instruction memory, and offers the
// returned word to the decoder on a valid/ready handshake. Each accepted word
// pulses pc_update for one cycle so the program counter adds pc_step (ternary +1).
// If a returned word contains the unassigned trit code, the unit stops in a
// sticky error state. Only flush or reset leaves that state.
//
// Trit encoding (2 bits per trit): 00 = zero, 01 = one, 10 = minus one,
// 11 = unassigned (invalid).
//
// Ports:
//   clock         in   clock; all state changes on posedge
//   reset_n       in   asynchronous active-low reset
//   fetch_enable  in   permits leaving IDLE to start a new fetch
//   flush         in   discards the buffered or in-flight instruction
//   pc            in   current program counter (2*MEM_ADDR_SIZE bits)
//   pc_update     out  one-cycle update-enable pulse to the program counter
//   pc_step       out  constant ternary +1 (2*WORD_SIZE bits)
//   mem_req       out  read request, held until mem_ready
//   mem_addr      out  read address, stable while mem_req=1
//   mem_ready     in   memory returns mem_rdata this cycle
//   mem_rdata     in   returned instruction word
//   instr_valid   out  instr/instr_addr hold a deliverable instruction
//   instr_ready   in   decoder accepts the instruction
//   instr         out  fetched instruction
//   instr_addr    out  address the instruction was fetched from
//   fetch_error   out  sticky invalid-trit indication
module ternary_fetch_unit #(
  parameter int unsigned WORD_SIZE     = 9,
  parameter int unsigned MEM_ADDR_SIZE = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       fetch_enable,
  input  logic                       flush,
  input  logic [2*MEM_ADDR_SIZE-1:0] pc,
  output logic                       pc_update,
  output logic [2*WORD_SIZE-1:0]     pc_step,
  output logic                       mem_req,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  input  logic                       mem_ready,
  input  logic [2*WORD_SIZE-1:0]     mem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [2*WORD_SIZE-1:0]     instr,
  output logic [2*MEM_ADDR_SIZE-1:0] instr_addr,
  output logic                       fetch_error
);

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  localparam logic [2*WORD_SIZE-1:0]     ZERO_WORD = {WORD_SIZE{TRIT_ZERO}};
  localparam logic [2*MEM_ADDR_SIZE-1:0] ZERO_ADDR = {MEM_ADDR_SIZE{TRIT_ZERO}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e                       state_q;
  logic                         mem_req_q;
  logic [2*MEM_ADDR_SIZE-1:0]   mem_addr_q;
  logic [2*WORD_SIZE-1:0]       instr_q;
  logic [2*MEM_ADDR_SIZE-1:0]   instr_addr_q;
  logic                         instr_valid_q;
  logic                         pc_update_q;
  logic                         fetch_error_q;
  logic                         drop_q;
  logic                         rdata_bad;

  // Any trit carrying the unassigned code marks the whole word as faulty.
  always_comb begin
    rdata_bad = 1'b0;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      if (mem_rdata[2*i +: 2] == TRIT_BAD) rdata_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= ZERO_ADDR;
      instr_q       <= ZERO_WORD;
      instr_addr_q  <= ZERO_ADDR;
      instr_valid_q <= 1'b0;
      pc_update_q   <= 1'b0;
      fetch_error_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      // pc_update is a single-cycle pulse; only the REQ->HOLD transition raises it.
      pc_update_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fetch_enable && !flush) begin
            mem_addr_q <= pc;
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // The request stays up until memory answers, even after a flush.
          // In that case the answer is remembered as stale and dropped.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (drop_q || flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else if (rdata_bad) begin
              fetch_error_q <= 1'b1;
              state_q       <= ERROR;
            end else begin
              instr_q       <= mem_rdata;
              instr_addr_q  <= mem_addr_q;
              instr_valid_q <= 1'b1;
              pc_update_q   <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          // flush and instr_ready both return the unit to IDLE. flush takes
          // priority, so when both are high the instruction is not delivered.
          if (flush || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        ERROR: begin
          if (flush) begin
            fetch_error_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_step     = {{(WORD_SIZE-1){TRIT_ZERO}}, TRIT_ONE};
  assign pc_update   = pc_update_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_addr  = instr_addr_q;
  assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Directed bench for ternary_fetch_unit. The stimulus process pushes the
// expected {instr, instr_addr} for each delivery it intends into a scoreboard.
// A negedge monitor pops and compares each entry when it sees a completed
// handshake. The monitor also counts pc_update pulses. The program counter
// model takes a base value plus the number of pulses seen, converted to
// balanced ternary.
module tb_ternary_fetch_unit;

  localparam int unsigned WS = 9;
  localparam int unsigned AS = 6;

  logic              clock;
  logic              reset_n;
  logic              fetch_enable;
  logic              flush;
  logic [2*AS-1:0]   pc;
  logic              pc_update;
  logic [2*WS-1:0]   pc_step;
  logic              mem_req;
  logic [2*AS-1:0]   mem_addr;
  logic              mem_ready;
  logic [2*WS-1:0]   mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [2*WS-1:0]   instr;
  logic [2*AS-1:0]   instr_addr;
  logic              fetch_error;

  ternary_fetch_unit #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetch_enable (fetch_enable),
    .flush        (flush),
    .pc           (pc),
    .pc_update    (pc_update),
    .pc_step      (pc_step),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_addr   (instr_addr),
    .fetch_error  (fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int pc_base     = 5;
  int upd_cnt     = 0;

  typedef struct packed {
    logic [2*WS-1:0] data;
    logic [2*AS-1:0] addr;
  } exp_t;
  exp_t sb[$];

  // Balanced-ternary encoder for the program counter model (00=0, 01=+1, 10=-1).
  function automatic logic [2*AS-1:0] enc_addr(input int value);
    logic [2*AS-1:0] r;
    int n;
    r = '0;
    n = value;
    for (int i = 0; i < int'(AS); i++) begin
      case (n % 3)
        0: begin r[2*i +: 2] = 2'b00; n = n / 3;       end
        1: begin r[2*i +: 2] = 2'b01; n = (n - 1) / 3; end
        default: begin r[2*i +: 2] = 2'b10; n = (n + 1) / 3; end
      endcase
    end
    return r;
  endfunction

  assign pc = enc_addr(pc_base + upd_cnt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake completes on the coming posedge when valid&ready are
  // high and no flush overrides it. Inputs only change at posedge+1.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pc_update) upd_cnt++;
      if (instr_valid && instr_ready && !flush) begin
        if (sb.size() == 0) begin
          check("unexpected_transfer", 32'(instr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_instr", 32'(instr), 32'(e.data));
          check("sb_instr_addr", 32'(instr_addr), 32'(e.addr));
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(mem_req), 32'd1);
  endtask

  // Wait for a request, check its address, then answer after `waits` idle cycles.
  task automatic serve(input int waits, input logic [2*WS-1:0] data,
                       input logic [2*AS-1:0] exp_addr, input string tag);
    wait_req(tag);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    for (int w = 0; w < waits; w++) begin
      step();
      check({tag, "_req_held"}, 32'(mem_req), 32'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  localparam logic [2*WS-1:0] D1  = 18'h12A45;
  localparam logic [2*WS-1:0] D2  = 18'h09864;
  localparam logic [2*WS-1:0] D3  = 18'h21142;
  localparam logic [2*WS-1:0] D4  = 18'h15555;
  localparam logic [2*WS-1:0] D5  = 18'h2AAAA;
  localparam logic [2*WS-1:0] BAD = 18'h00030;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    fetch_enable = 1'b0;
    flush        = 1'b0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    instr_ready  = 1'b0;
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_pc_update", 32'(pc_update), 32'd0);
    check("rst_fetch_error", 32'(fetch_error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("pc_step", 32'(pc_step), 32'h00001);
    step(); step();
    reset_n = 1'b1;
    step();

    // T1: address 5 (12'h01A), two wait cycles, decoder ready.
    instr_ready  = 1'b1;
    fetch_enable = 1'b1;
    sb.push_back('{data: D1, addr: 12'h01A});
    serve(2, D1, 12'h01A, "t1");
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_pc_update", 32'(pc_update), 32'd1);
    check("t1_instr", 32'(instr), 32'(D1));
    check("t1_instr_addr", 32'(instr_addr), 32'h01A);
    step();
    check("t1_valid_drop", 32'(instr_valid), 32'd0);
    check("t1_pc_update_once", 32'(pc_update), 32'd0);
    check("t1_upd_cnt", 32'(upd_cnt), 32'd1);

    // T2: next fetch from address 6 (12'h018); decoder stalls 4 cycles in HOLD.
    instr_ready = 1'b0;
    sb.push_back('{data: D2, addr: 12'h018});
    serve(0, D2, 12'h018, "t2");
    fetch_enable = 1'b0;
    check("t2_pc_update", 32'(pc_update), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_hold_instr", 32'(instr), 32'(D2));
      check("t2_hold_addr", 32'(instr_addr), 32'h018);
      check("t2_hold_no_req", 32'(mem_req), 32'd0);
      check("t2_hold_no_upd", 32'(pc_update), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    check("t2_valid_drop", 32'(instr_valid), 32'd0);
    check("t2_upd_cnt", 32'(upd_cnt), 32'd2);

    // T3: flush while REQ is outstanding at address 7 (12'h019).
    fetch_enable = 1'b1;
    wait_req("t3");
    check("t3_mem_addr", 32'(mem_addr), 32'h019);
    fetch_enable = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_req_held_a", 32'(mem_req), 32'd1);
    step();
    check("t3_req_held_b", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = D3;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    check("t3_no_valid", 32'(instr_valid), 32'd0);
    check("t3_no_upd", 32'(pc_update), 32'd0);
    check("t3_req_low", 32'(mem_req), 32'd0);
    step();
    check("t3_idle_no_req", 32'(mem_req), 32'd0);
    check("t3_upd_cnt", 32'(upd_cnt), 32'd2);

    // T4: flush and instr_ready together in HOLD; no transfer.
    instr_ready = 1'b0;
    fetch_enable = 1'b1;
    serve(0, D4, 12'h019, "t4");
    check("t4_valid", 32'(instr_valid), 32'd1);
    fetch_enable = 1'b0;
    flush = 1'b1;
    instr_ready = 1'b1;
    step();
    flush = 1'b0;
    instr_ready = 1'b0;
    check("t4_valid_drop", 32'(instr_valid), 32'd0);
    step();
    check("t4_upd_cnt", 32'(upd_cnt), 32'd3);

    // T5: invalid trit at address 8 (12'h012), error is sticky until flush.
    instr_ready = 1'b1;
    fetch_enable = 1'b1;
    serve(0, BAD, 12'h012, "t5");
    check("t5_error", 32'(fetch_error), 32'd1);
    check("t5_no_valid", 32'(instr_valid), 32'd0);
    check("t5_no_upd", 32'(pc_update), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_no_req", 32'(mem_req), 32'd0);
      check("t5_error_sticky", 32'(fetch_error), 32'd1);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_error_clear", 32'(fetch_error), 32'd0);
    sb.push_back('{data: D5, addr: 12'h012});
    serve(1, D5, 12'h012, "t5r");
    fetch_enable = 1'b0;
    check("t5r_valid", 32'(instr_valid), 32'd1);
    check("t5r_instr", 32'(instr), 32'(D5));
    step(); step();
    check("t5r_valid_drop", 32'(instr_valid), 32'd0);
    check("t5r_upd_cnt", 32'(upd_cnt), 32'd4);

    // T6: asynchronous reset mid-REQ at address 9 (12'h010).
    fetch_enable = 1'b1;
    wait_req("t6");
    check("t6_mem_addr", 32'(mem_addr), 32'h010);
    fetch_enable = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_upd", 32'(pc_update), 32'd0);
    check("t6_rst_err", 32'(fetch_error), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_instr", 32'(instr), 32'd0);
    check("t6_rst_iaddr", 32'(instr_addr), 32'd0);
    step();
    reset_n = 1'b1;
    step(); step();
    check("t6_post_req", 32'(mem_req), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
